// File: rtl/median_pkg.sv
// Shared types and constants for the streaming 3x3 median filter.
package median_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int BORDER_ZERO = 0;
  localparam int BORDER_PASS = 1;

endpackage

// File: rtl/median9.sv
// Combinational 9-input median: 19 compare-exchange stages, result is the 5th smallest (unsigned).
module median9 #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [8:0][DATA_WIDTH-1:0] pix,
  output logic [DATA_WIDTH-1:0]      med
);

  // Returns {larger, smaller} so the pair lands back in ascending index order.
  function automatic logic [2*DATA_WIDTH-1:0] sort2(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
    return (a > b) ? {a, b} : {b, a};
  endfunction

  logic [8:0][DATA_WIDTH-1:0] p;

  always_comb begin
    p = pix;
    {p[2], p[1]} = sort2(p[1], p[2]);
    {p[5], p[4]} = sort2(p[4], p[5]);
    {p[8], p[7]} = sort2(p[7], p[8]);
    {p[1], p[0]} = sort2(p[0], p[1]);
    {p[4], p[3]} = sort2(p[3], p[4]);
    {p[7], p[6]} = sort2(p[6], p[7]);
    {p[2], p[1]} = sort2(p[1], p[2]);
    {p[5], p[4]} = sort2(p[4], p[5]);
    {p[8], p[7]} = sort2(p[7], p[8]);
    {p[3], p[0]} = sort2(p[0], p[3]);
    {p[8], p[5]} = sort2(p[5], p[8]);
    {p[7], p[4]} = sort2(p[4], p[7]);
    {p[6], p[3]} = sort2(p[3], p[6]);
    {p[4], p[1]} = sort2(p[1], p[4]);
    {p[5], p[2]} = sort2(p[2], p[5]);
    {p[7], p[4]} = sort2(p[4], p[7]);
    {p[2], p[4]} = sort2(p[4], p[2]);
    {p[4], p[6]} = sort2(p[6], p[4]);
    {p[2], p[4]} = sort2(p[4], p[2]);
    med = p[4];
  end

endmodule

// File: rtl/median3x3_stream.sv
// Raster-order streaming 3x3 median filter: two line buffers, a 3x3 window register,
// edge masking (zero-pad or pass-through) and a registered median output.
module median3x3_stream
  import median_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int IMG_WIDTH   = 256,
  parameter int IMG_HEIGHT  = 256,
  parameter int BORDER_MODE = BORDER_ZERO
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  input  logic                  Valid_IN,
  output logic                  Ready_OUT,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  Valid_OUT,
  output state_t                state_dbg
);

  // Handshake: an input beat is taken on a rising edge with Valid_IN && Ready_OUT.
  // Ready_OUT is low only in FLUSH. Valid_OUT qualifies DATA_OUT for one cycle; no backpressure.

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int FW = $clog2(IMG_WIDTH + 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_HEIGHT - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(IMG_WIDTH);

  state_t state, state_nx;
  logic [CW-1:0] col, ocol, wcol;
  logic [RW-1:0] row, orow, wrow;
  logic [FW-1:0] fcnt;
  logic beat, produce, wv;
  logic [DATA_WIDTH-1:0] pix_in, med9, med_out;
  logic [DATA_WIDTH-1:0] lb0 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] win [3][3];
  logic [8:0][DATA_WIDTH-1:0] taps;
  logic top, bot, left, right;

  assign state_dbg = state;
  assign pix_in    = (state == FLUSH) ? '0 : DATA_IN;

  always_comb begin
    state_nx  = state;
    Ready_OUT = (state != FLUSH);
    beat      = 1'b0;
    produce   = 1'b0;
    case (state)
      // The beat carrying pixel (1,0) is the last of the W+1 fill beats.
      FILL: begin
        beat = Valid_IN;
        if (Valid_IN && row == RW'(1) && col == '0) state_nx = RUN;
      end
      RUN: begin
        beat    = Valid_IN;
        produce = Valid_IN;
        if (Valid_IN && row == ROW_LAST && col == COL_LAST) state_nx = FLUSH;
      end
      FLUSH: begin
        beat    = 1'b1;
        produce = 1'b1;
        if (fcnt == FLUSH_LAST) state_nx = FILL;
      end
      default: state_nx = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FILL;
      row       <= '0;
      col       <= '0;
      fcnt      <= '0;
      orow      <= '0;
      ocol      <= '0;
      wrow      <= '0;
      wcol      <= '0;
      wv        <= 1'b0;
      Valid_OUT <= 1'b0;
      DATA_OUT  <= '0;
    end else begin
      state     <= state_nx;
      wv        <= produce;
      Valid_OUT <= wv;
      if (wv) DATA_OUT <= med_out;
      if (beat) begin
        if (state == FLUSH) begin
          // Column keeps running so line-buffer reads stay aligned; frame ends at (0,0).
          fcnt <= (fcnt == FLUSH_LAST) ? '0 : fcnt + 1'b1;
          col  <= (col == COL_LAST || fcnt == FLUSH_LAST) ? '0 : col + 1'b1;
          row  <= '0;
        end else if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (produce) begin
        wrow <= orow;
        wcol <= ocol;
        if (ocol == COL_LAST) begin
          ocol <= '0;
          orow <= (orow == ROW_LAST) ? '0 : orow + 1'b1;
        end else begin
          ocol <= ocol + 1'b1;
        end
      end
    end
  end

  // Data path is unreset: stale contents are always masked or never reach an output.
  always_ff @(posedge clk) begin
    if (beat) begin
      lb0[col] <= pix_in;
      lb1[col] <= lb0[col];
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= lb1[col];
      win[1][2] <= lb0[col];
      win[2][2] <= pix_in;
    end
  end

  assign top   = (wrow == '0);
  assign bot   = (wrow == ROW_LAST);
  assign left  = (wcol == '0);
  assign right = (wcol == COL_LAST);

  for (genvar r = 0; r < 3; r++) begin : g_row
    for (genvar c = 0; c < 3; c++) begin : g_col
      assign taps[r*3+c] = ((r == 0 && top) || (r == 2 && bot) ||
                            (c == 0 && left) || (c == 2 && right)) ? '0 : win[r][c];
    end
  end

  median9 #(.DATA_WIDTH(DATA_WIDTH)) u_median9 (
    .pix (taps),
    .med (med9)
  );

  assign med_out = (BORDER_MODE == BORDER_PASS && (top || bot || left || right)) ? win[1][1] : med9;

endmodule

// File: tb/tb_median3x3_stream.sv
// Directed bench for median3x3_stream: 4x4 zero-pad and pass-through instances plus a default-size instance.
module tb_median3x3_stream;
  import median_pkg::*;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int BW = 256;
  localparam int BH = 256;

  localparam logic [7:0] EXP_CONST [16] = '{8'd0,   8'd100, 8'd100, 8'd0,
                                            8'd100, 8'd100, 8'd100, 8'd100,
                                            8'd100, 8'd100, 8'd100, 8'd100,
                                            8'd0,   8'd100, 8'd100, 8'd0};
  // Gradient frame (r,c) = 10*(4r+c+1), zero-padded medians worked by hand.
  localparam logic [7:0] EXP_GRAD [16] = '{8'd0,  8'd20,  8'd30,  8'd0,
                                           8'd20, 8'd60,  8'd70,  8'd40,
                                           8'd60, 8'd100, 8'd110, 8'd80,
                                           8'd0,  8'd100, 8'd110, 8'd0};

  // Clock and reset
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] din, din_b, dz, dp, db;
  logic       vin, vin_b, rdy_z, rdy_p, rdy_b, vz, vp, vb;
  state_t     st_z, st_p, st_b;

  median3x3_stream #(.DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .BORDER_MODE(BORDER_ZERO)) u_zero (
    .clk(clk), .reset(reset), .DATA_IN(din), .Valid_IN(vin), .Ready_OUT(rdy_z),
    .DATA_OUT(dz), .Valid_OUT(vz), .state_dbg(st_z));
  median3x3_stream #(.DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .BORDER_MODE(BORDER_PASS)) u_pass (
    .clk(clk), .reset(reset), .DATA_IN(din), .Valid_IN(vin), .Ready_OUT(rdy_p),
    .DATA_OUT(dp), .Valid_OUT(vp), .state_dbg(st_p));
  median3x3_stream u_big (
    .clk(clk), .reset(reset), .DATA_IN(din_b), .Valid_IN(vin_b), .Ready_OUT(rdy_b),
    .DATA_OUT(db), .Valid_OUT(vb), .state_dbg(st_b));

  // Checking
  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard on the selected instance (0 zero-pad, 1 pass-through, 2 big, 3 none)
  logic [7:0] exp_q[$];
  int         sel = 3;
  int         pulses = 0;
  int         first_v_cyc = -1;
  string      tag = "none";
  logic       mon_v;
  logic [7:0] mon_d;

  assign mon_v = (sel == 0) ? vz : (sel == 1) ? vp : (sel == 2) ? vb : 1'b0;
  assign mon_d = (sel == 0) ? dz : (sel == 1) ? dp : db;

  always @(negedge clk) begin
    if (mon_v) begin
      pulses++;
      if (first_v_cyc < 0) first_v_cyc = cyc;
      if (exp_q.size() == 0) check({tag, " unexpected output"}, 32'(exp_q.size()), 32'd1);
      else check(tag, 32'(mon_d), 32'(exp_q.pop_front()));
    end
  end

  // Drivers
  logic [7:0] img [16];
  logic [7:0] img_b [BW*BH];

  task automatic idle(input int n);
    vin = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] v);
    logic acc = 1'b0;
    din = v;
    vin = 1'b1;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      acc = rdy_z;
      @(posedge clk); #1;
    end
    if (!acc) check({tag, " send accept"}, 32'(acc), 32'd1);
    vin = 1'b0;
  endtask

  // Valid pattern 1,0,0,1 repeating when gaps is set.
  task automatic send_frame(input bit gaps, input int first);
    int p = 0;
    for (int i = first; i < 16; i++) begin
      if (gaps) while (p % 4 == 1 || p % 4 == 2) begin idle(1); p++; end
      send(img[i]);
      p++;
    end
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int t = 0; t < max_cycles && exp_q.size() != 0; t++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check({tag, " drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic push_table(input int which);
    for (int i = 0; i < 16; i++) exp_q.push_back(which == 0 ? EXP_CONST[i] : which == 1 ? EXP_GRAD[i] : 8'd50);
  endtask

  task automatic load_img(input int which);
    for (int i = 0; i < 16; i++) img[i] = (which == 0) ? 8'd100 : (which == 1) ? 8'(10 * (i + 1)) : 8'd50;
    if (which == 2) img[5] = 8'd255;
  endtask

  function automatic logic [7:0] ref_med(input int r, input int c);
    logic [7:0] v [9];
    logic [7:0] t;
    int n = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        v[n] = (r + dr < 0 || r + dr >= BH || c + dc < 0 || c + dc >= BW) ? 8'd0 : img_b[(r + dr) * BW + c + dc];
        n++;
      end
    for (int i = 1; i < 9; i++)
      for (int j = i; j > 0 && v[j-1] > v[j]; j--) begin
        t = v[j]; v[j] = v[j-1]; v[j-1] = t;
      end
    return v[4];
  endfunction

  initial begin
    int lowc;
    int beat_cyc;
    reset = 1'b1; din = '0; vin = 1'b0; din_b = '0; vin_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset valid_out", 32'(vz), 32'd0);
    check("reset data_out", 32'(dz), 32'd0);
    check("reset state", 32'(st_z), 32'(FILL));
    reset = 1'b0;
    @(posedge clk); #1;
    check("reset ready", 32'(rdy_z), 32'd1);

    // Constant 100, zero pad
    sel = 0; tag = "const100"; pulses = 0;
    load_img(0); push_table(0); send_frame(1'b0, 0); wait_drain(100);
    check("const100 pulses", 32'(pulses), 32'd16);

    // Gradient, zero pad, gap-free then gapped
    tag = "grad"; pulses = 0;
    load_img(1); push_table(1); send_frame(1'b0, 0); wait_drain(100);
    check("grad pulses", 32'(pulses), 32'd16);
    tag = "grad gaps"; pulses = 0;
    push_table(1); send_frame(1'b1, 0); wait_drain(100);
    check("grad gaps pulses", 32'(pulses), 32'd16);

    // Spike at (1,1), pass-through border, gap-free then gapped
    sel = 1; tag = "spike"; pulses = 0;
    load_img(2); push_table(2); send_frame(1'b0, 0); wait_drain(100);
    check("spike pulses", 32'(pulses), 32'd16);
    tag = "spike gaps"; pulses = 0;
    push_table(2); send_frame(1'b1, 0); wait_drain(100);
    check("spike gaps pulses", 32'(pulses), 32'd16);

    // Frame end: ready low for W+1 cycles, 255 offered meanwhile, back-to-back second frame
    sel = 0; tag = "b2b"; pulses = 0;
    load_img(0); push_table(0); push_table(0);
    send_frame(1'b0, 0);
    din = 8'd255; vin = 1'b1; lowc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rdy_z) break;
      lowc++;
    end
    check("flush ready low cycles", 32'(lowc), 32'd5);
    din = img[0];
    @(posedge clk); #1;
    send_frame(1'b0, 1);
    wait_drain(100);
    check("b2b pulses", 32'(pulses), 32'd32);

    // Reset after 7 accepted pixels, then a clean frame
    sel = 3; tag = "pre-reset";
    for (int i = 0; i < 7; i++) send(8'd100);
    #2 reset = 1'b1;
    #1;
    check("midframe reset valid_out", 32'(vz), 32'd0);
    check("midframe reset data_out", 32'(dz), 32'd0);
    check("midframe reset pass data_out", 32'(dp), 32'd0);
    check("midframe reset state", 32'(st_z), 32'(FILL));
    @(negedge clk); reset = 1'b0;
    #1;
    check("post reset ready", 32'(rdy_z), 32'd1);
    @(posedge clk); #1;
    sel = 0; tag = "after reset"; pulses = 0; exp_q.delete();
    push_table(0); send_frame(1'b0, 0); wait_drain(100);
    check("after reset pulses", 32'(pulses), 32'd16);

    // Default 256x256 random frame against the sort model, plus first-output latency
    sel = 2; tag = "big"; pulses = 0; first_v_cyc = -1; beat_cyc = -1;
    for (int i = 0; i < BW * BH; i++) img_b[i] = 8'($urandom_range(0, 255));
    for (int r = 0; r < BH; r++)
      for (int c = 0; c < BW; c++) exp_q.push_back(ref_med(r, c));
    for (int i = 0; i < BW * BH; i++) begin
      din_b = img_b[i];
      vin_b = 1'b1;
      if (i == BW + 1) beat_cyc = cyc;
      @(posedge clk); #1;
    end
    vin_b = 1'b0;
    wait_drain(1000);
    check("big pulses", 32'(pulses), 32'(BW * BH));
    check("big first output latency", 32'(first_v_cyc - beat_cyc), 32'd2);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
